fractal_generator: RTL and testbench
====================================

FRACTAL_GENERATOR -- requirements
Module: fractal_generator

Interface
REQ-001 Parameter: MAX_ITER, default 255 (legal range 1..255), iteration cap; also the data value for non-escaping pixels.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 width  in  16  pixels per line, unsigned.
REQ-005 height  in  16  lines per frame, unsigned.
REQ-006 cr, ci  in  32 each  Julia constant c, signed Q4.28 (0x10000000 = 1.0).
REQ-007 dx, dy  in  32 each  per-column / per-row step, signed Q4.28.
REQ-008 x0, y0  in  32 each  origin offsets, signed Q4.28.
REQ-009 data  out  8  escape iteration count of current pixel.
REQ-010 data_enable  out  1  high for exactly one cycle per pixel; data valid in that cycle.
REQ-011 frame_start  out  1  high only together with data_enable, on pixel (col 0, row 0).
REQ-012 line_end  out  1  high only together with data_enable, on pixel col = width-1.

Function
REQ-013 Raster order: row 0..height-1, col 0..width-1 within row; after the last pixel the next frame starts immediately, free-running.
REQ-014 width, height, cr, ci, dx, dy, x0, y0 latched once, at start of pixel (0,0); mid-frame input changes take effect at the next frame only.
REQ-015 width or height of 0 treated as 1.
REQ-016 Start point: zr0 = col*dx - x0, zi0 = y0 - row*dy, generated by accumulators (reload to -x0 per line, add dx per column; load y0 per frame, subtract dy per row), 32-bit two's-complement wrap.
REQ-017 Iteration: zr' = zr^2 - zi^2 + cr, zi' = 2*zr*zi + ci; products full 64-bit signed, rescaled by arithmetic shift right 28 (bits [59:28]); sums wrap to 32 bits.
REQ-018 Escape test: zr^2 + zi^2 at full product precision (Q8.56, >=65-bit sum) compared strictly greater than 4.0 (4 << 56).
REQ-019 Count: n = 0; each ITER cycle: if escaped or n == MAX_ITER, finish with data = n; else update z, n = n+1. Already-escaped start point gives 0; never-escaping gives MAX_ITER.
REQ-020 FSM: LOAD (1 cycle, init z and n) -> ITER (n+1 cycles) -> EMIT (1 cycle, data_enable = 1, data/flags registered) -> LOAD of next pixel; pixel period = n+3 cycles.
REQ-021 Outside EMIT: data_enable, frame_start, line_end = 0; data holds last value.
REQ-022 Single pixel at a time; no back-pressure input; pixel (0,0) always carries frame_start, last column always line_end (both if width = 1).

Reset
REQ-023 resetn low asynchronously clears data, data_enable, frame_start, line_end to 0, counters to 0, FSM to LOAD.
REQ-024 First rising edge with resetn high begins LOAD of pixel (0,0) of a new frame; reset mid-frame abandons the frame, no partial flags emitted.

Verification
REQ-025 resetn held low 150 ns -> all outputs 0 throughout; after release first data_enable carries frame_start = 1.
REQ-026 width=384, height=216, cr=0xF999999A, ci=0x09999999, dx=dy=0x00155555, x0=0x10000000, y0=0x09000000 -> between consecutive frame_start pulses exactly 82944 data_enable pulses and 216 line_end pulses, each line_end on every 384th pixel; dumped image is a connected Julia set.
REQ-027 width=2, height=1, c=0, x0=0x30000000, dx=0x20000000, y0=dy=0 -> pixel0 data=0 with frame_start, 3-cycle period; pixel1 (z=-1) data=255 with line_end, 258-cycle period; then frame_start again.
REQ-028 width=height=1, c=0, x0=0xE8000000 (zr0=1.5), y0=0 -> data=1 each frame, frame_start and line_end both high, period 4 cycles.
REQ-029 Change width from 384 to 768 mid-frame -> current frame still 384x216 pixels; following frame 768 per line.
REQ-030 resetn pulsed low mid-line -> outputs 0 immediately (no clock needed); after release pixel (0,0) with frame_start re-emitted.

Source files
------------

// File: rtl/fractal_generator.sv
// Free-running Julia-set raster generator: one pixel at a time through LOAD/ITER/EMIT,
// streaming the escape iteration count with frame/line markers.
module fractal_generator #(
    parameter int unsigned MAX_ITER = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] width,
    input  logic [15:0] height,
    input  logic [31:0] cr,
    input  logic [31:0] ci,
    input  logic [31:0] dx,
    input  logic [31:0] dy,
    input  logic [31:0] x0,
    input  logic [31:0] y0,
    output logic [7:0]  data,
    output logic        data_enable,
    output logic        frame_start,
    output logic        line_end
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        ITER = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t state_r;
    state_t state_s;

    logic [15:0] width_r;
    logic [15:0] height_r;
    logic [31:0] cr_r;
    logic [31:0] ci_r;
    logic [31:0] dx_r;
    logic [31:0] dy_r;
    logic [31:0] x0_r;
    logic [31:0] y0_r;
    logic [15:0] col_r;
    logic [15:0] row_r;
    logic [31:0] acc_re_r;
    logic [31:0] acc_im_r;
    logic [31:0] zr_r;
    logic [31:0] zi_r;
    logic [7:0]  n_r;

    logic signed [63:0] zr_ext_s;
    logic signed [63:0] zi_ext_s;
    logic signed [63:0] p_rr_s;
    logic signed [63:0] p_ii_s;
    logic signed [63:0] p_ri_s;
    logic [64:0]        mag_s;
    logic               escaped_s;
    logic               done_s;
    logic [31:0]        zr_next_s;
    logic [31:0]        zi_next_s;
    logic               first_pixel_s;
    logic               last_col_s;
    logic               last_row_s;
    logic               emit_s;
    logic               fs_next_s;
    logic               le_next_s;
    logic               unused_bits_s;

    assign zr_ext_s = {{32{zr_r[31]}}, zr_r};
    assign zi_ext_s = {{32{zi_r[31]}}, zi_r};
    assign p_rr_s   = zr_ext_s * zr_ext_s;
    assign p_ii_s   = zi_ext_s * zi_ext_s;
    assign p_ri_s   = zr_ext_s * zi_ext_s;

    // Both squares are non-negative, so the zero-extended sum is exact.
    assign mag_s     = {1'b0, p_rr_s} + {1'b0, p_ii_s};
    assign escaped_s = (mag_s > 65'h0_0400_0000_0000_0000);
    assign done_s    = escaped_s || (n_r == 8'(MAX_ITER));

    // Doubling the cross product shifts its Q8.56 window down by one bit.
    assign zr_next_s = p_rr_s[59:28] - p_ii_s[59:28] + cr_r;
    assign zi_next_s = p_ri_s[58:27] + ci_r;
    assign unused_bits_s = ^{p_ri_s[63:59], p_ri_s[26:0]};

    assign first_pixel_s = (col_r == 16'd0) && (row_r == 16'd0);
    assign last_col_s    = (col_r == (width_r - 16'd1));
    assign last_row_s    = (row_r == (height_r - 16'd1));

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = LOAD;
        case (state_r)
            LOAD:    state_s = ITER;
            ITER:    state_s = done_s ? EMIT : ITER;
            EMIT:    state_s = LOAD;
            default: state_s = LOAD;
        endcase
    end

    // Output decode: values the output registers capture for the EMIT cycle.
    always_comb begin
        emit_s    = 1'b0;
        fs_next_s = 1'b0;
        le_next_s = 1'b0;
        if ((state_r == ITER) && done_s) begin
            emit_s    = 1'b1;
            fs_next_s = first_pixel_s;
            le_next_s = last_col_s;
        end else begin
            emit_s    = 1'b0;
            fs_next_s = 1'b0;
            le_next_s = 1'b0;
        end
    end

    // Pixel datapath: frame latch, start-point accumulators, iteration and raster counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            width_r  <= 16'd0;
            height_r <= 16'd0;
            cr_r     <= 32'd0;
            ci_r     <= 32'd0;
            dx_r     <= 32'd0;
            dy_r     <= 32'd0;
            x0_r     <= 32'd0;
            y0_r     <= 32'd0;
            col_r    <= 16'd0;
            row_r    <= 16'd0;
            acc_re_r <= 32'd0;
            acc_im_r <= 32'd0;
            zr_r     <= 32'd0;
            zi_r     <= 32'd0;
            n_r      <= 8'd0;
        end else begin
            case (state_r)
                LOAD: begin
                    n_r <= 8'd0;
                    if (first_pixel_s) begin
                        width_r  <= (width == 16'd0) ? 16'd1 : width;
                        height_r <= (height == 16'd0) ? 16'd1 : height;
                        cr_r     <= cr;
                        ci_r     <= ci;
                        dx_r     <= dx;
                        dy_r     <= dy;
                        x0_r     <= x0;
                        y0_r     <= y0;
                        zr_r     <= 32'd0 - x0;
                        zi_r     <= y0;
                        acc_re_r <= 32'd0 - x0;
                        acc_im_r <= y0;
                    end else begin
                        zr_r <= acc_re_r;
                        zi_r <= acc_im_r;
                    end
                end
                ITER: begin
                    if (!done_s) begin
                        zr_r <= zr_next_s;
                        zi_r <= zi_next_s;
                        n_r  <= n_r + 8'd1;
                    end
                end
                EMIT: begin
                    if (last_col_s) begin
                        col_r    <= 16'd0;
                        acc_re_r <= 32'd0 - x0_r;
                        if (last_row_s) begin
                            row_r <= 16'd0;
                        end else begin
                            row_r    <= row_r + 16'd1;
                            acc_im_r <= acc_im_r - dy_r;
                        end
                    end else begin
                        col_r    <= col_r + 16'd1;
                        acc_re_r <= acc_re_r + dx_r;
                    end
                end
                default: begin
                    n_r <= 8'd0;
                end
            endcase
        end
    end

    // Registered pixel outputs; data holds its last value between pixels.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data        <= 8'd0;
            data_enable <= 1'b0;
            frame_start <= 1'b0;
            line_end    <= 1'b0;
        end else begin
            data_enable <= emit_s;
            frame_start <= fs_next_s;
            line_end    <= le_next_s;
            if (emit_s) begin
                data <= n_r;
            end else begin
                data <= data;
            end
        end
    end

endmodule

// File: tb/tb_fractal_generator.sv
// Scoreboard bench for fractal_generator: directed small frames with hand-computed
// iteration counts, flags and pixel periods.
module tb_fractal_generator;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] width;
    logic [15:0] height;
    logic [31:0] cr;
    logic [31:0] ci;
    logic [31:0] dx;
    logic [31:0] dy;
    logic [31:0] x0;
    logic [31:0] y0;
    logic [7:0]  data;
    logic        data_enable;
    logic        frame_start;
    logic        line_end;

    typedef struct {
        logic [7:0] d;
        logic       fs;
        logic       le;
        int         gap;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   last_emit = -1;

    fractal_generator #(.MAX_ITER(255)) dut (
        .clk(clk), .resetn(resetn),
        .width(width), .height(height),
        .cr(cr), .ci(ci), .dx(dx), .dy(dy), .x0(x0), .y0(y0),
        .data(data), .data_enable(data_enable),
        .frame_start(frame_start), .line_end(line_end)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every data_enable and checks idle-cycle flags.
    always @(negedge clk) begin
        cyc++;
        if (!resetn) begin
            last_emit = -1;
        end else if (data_enable) begin
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("data", 32'(data), 32'(mon_e.d));
                check("frame_start", 32'(frame_start), 32'(mon_e.fs));
                check("line_end", 32'(line_end), 32'(mon_e.le));
                if (mon_e.gap >= 0) begin
                    check("pixel_period", 32'(cyc - last_emit), 32'(mon_e.gap));
                end
            end
            last_emit = cyc;
        end else begin
            check("idle_flags", {30'd0, frame_start, line_end}, 32'd0);
        end
    end

    task automatic push(input logic [7:0] d, input logic fs, input logic le, input int gap);
        exp_t e;
        e.d = d; e.fs = fs; e.le = le; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic config_set(input logic [15:0] w, input logic [15:0] h,
                              input logic [31:0] c_r, input logic [31:0] c_i,
                              input logic [31:0] sx, input logic [31:0] sy,
                              input logic [31:0] ox, input logic [31:0] oy);
        width = w; height = h; cr = c_r; ci = c_i; dx = sx; dy = sy; x0 = ox; y0 = oy;
    endtask

    // Asynchronous assert, outputs must clear without a clock edge, release on a falling edge.
    task automatic pulse_reset(input int n);
        resetn = 1'b0;
        #1;
        check("reset_async_clear", {21'd0, data, data_enable, frame_start, line_end}, 32'd0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("reset_hold", {21'd0, data, data_enable, frame_start, line_end}, 32'd0);
        end
        resetn = 1'b1;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() > 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        resetn = 1'b0;
        // zr0 = 1.5: one iteration to escape, 4-cycle period, both flags every frame.
        config_set(16'd1, 16'd1, 32'h0, 32'h0, 32'h0, 32'h0, 32'hE800_0000, 32'h0);
        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("reset_hold_150ns", {21'd0, data, data_enable, frame_start, line_end}, 32'd0);
        end
        resetn = 1'b1;
        push(8'd1, 1'b1, 1'b1, -1);
        push(8'd1, 1'b1, 1'b1, 4);
        push(8'd1, 1'b1, 1'b1, 4);
        drain(200);

        // Two pixels: zr=-3 escapes at once, zr=-1 never escapes; width raised mid-frame.
        @(negedge clk);
        config_set(16'd2, 16'd1, 32'h0, 32'h0, 32'h2000_0000, 32'h0, 32'h3000_0000, 32'h0);
        pulse_reset(3);
        push(8'd0, 1'b1, 1'b0, -1);
        push(8'd255, 1'b0, 1'b1, 258);
        push(8'd0, 1'b1, 1'b0, 3);
        for (int k = 0; k < 100 && exp_q.size() > 2; k++) begin
            @(negedge clk);
        end
        width = 16'd3;
        push(8'd255, 1'b0, 1'b0, 258);
        push(8'd255, 1'b0, 1'b1, 258);
        drain(3000);

        // Strict escape boundary: |z|^2 == 4.0 keeps iterating, 4.0 + tiny escapes.
        config_set(16'd2, 16'd1, 32'h0, 32'h0, 32'h0000_0001, 32'h0, 32'hE000_0000, 32'h0);
        pulse_reset(2);
        push(8'd1, 1'b1, 1'b0, -1);
        push(8'd0, 1'b0, 1'b1, 3);
        push(8'd1, 1'b1, 1'b0, 4);
        drain(200);

        // Zero width/height behave as one pixel.
        config_set(16'd0, 16'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hDFFF_FFFF, 32'h0);
        pulse_reset(2);
        push(8'd0, 1'b1, 1'b1, -1);
        push(8'd0, 1'b1, 1'b1, 3);
        drain(200);

        // Column of two rows: zi0 = 2.0 then 1.0 via the dy accumulator.
        config_set(16'd1, 16'd2, 32'h0, 32'h0, 32'h0, 32'h1000_0000, 32'h0, 32'h2000_0000);
        pulse_reset(2);
        push(8'd1, 1'b1, 1'b1, -1);
        push(8'd255, 1'b0, 1'b1, 258);
        push(8'd1, 1'b1, 1'b1, 4);
        drain(1000);

        // z0 = 1+i, c = 0: exercises the doubled cross term.
        config_set(16'd1, 16'd1, 32'h0, 32'h0, 32'h0, 32'h0, 32'hF000_0000, 32'h1000_0000);
        pulse_reset(2);
        push(8'd2, 1'b1, 1'b1, -1);
        push(8'd2, 1'b1, 1'b1, 5);
        drain(200);

        // z0 = 0, c = -1+i: orbit -1+i, -1-i, -1+3i escapes at n=3.
        config_set(16'd1, 16'd1, 32'hF000_0000, 32'h1000_0000, 32'h0, 32'h0, 32'h0, 32'h0);
        pulse_reset(2);
        push(8'd3, 1'b1, 1'b1, -1);
        push(8'd3, 1'b1, 1'b1, 6);
        drain(200);

        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
